// File: rtl/jedro_1_decoder_pipe.sv
// jedro_1_decoder_pipe: RV32I/RV32E instruction decoder with a registered
// valid/ready output stage (main register plus optional skid register).
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   instr_valid_i/instr_rdata_i  fetch word handshake, instr_ready_o back-pressure
//   flush_i                      discard every buffered entry
//   illegal_clr_i                clear the sticky illegal flag
//   dec_valid_o/dec_ready_i      decoded entry handshake
//   dec_*                        decoded fields of the entry in the main register
//   illegal_sticky_o             an illegal entry left the decoder since the last clear
module jedro_1_decoder_pipe #(
    parameter bit RVE     = 1'b0,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              instr_valid_i,
    input  logic [31:0]                       instr_rdata_i,
    output logic                              instr_ready_o,
    input  logic                              flush_i,
    input  logic                              illegal_clr_i,
    output logic                              dec_valid_o,
    input  logic                              dec_ready_i,
    output logic [3:0]                        dec_alu_op_o,
    output logic                              dec_reg_a_o,
    output logic                              dec_reg_b_o,
    output logic [(RVE ? 4 : 5)-1:0]          dec_rs1_addr_o,
    output logic [(RVE ? 4 : 5)-1:0]          dec_rs2_addr_o,
    output logic [(RVE ? 4 : 5)-1:0]          dec_rd_addr_o,
    output logic                              dec_rd_we_o,
    output logic [31:0]                       dec_imm_o,
    output logic                              dec_lsu_en_o,
    output logic [3:0]                        dec_lsu_ctrl_o,
    output logic                              dec_branch_o,
    output logic                              dec_jump_o,
    output logic                              dec_illegal_o,
    output logic                              illegal_sticky_o
);

    localparam int unsigned RAW = RVE ? 4 : 5;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [3:0]     alu_op;
        logic           reg_a;
        logic           reg_b;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
        logic [RAW-1:0] rd;
        logic           rd_we;
        logic [31:0]    imm;
        logic           lsu_en;
        logic [3:0]     lsu_ctrl;
        logic           branch;
        logic           jump;
        logic           illegal;
    } dec_t;

    dec_t main_q;
    dec_t skid_q;
    dec_t dec_c;
    logic main_vld_q;
    logic skid_vld_q;
    logic live_q;
    logic sticky_q;
    logic in_fire;
    logic out_fire;

    // Combinational decode of the incoming fetch word.
    always_comb begin
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        logic        writes_rd;
        logic        ill;

        opcode    = instr_rdata_i[6:0];
        funct3    = instr_rdata_i[14:12];
        funct7    = instr_rdata_i[31:25];
        imm_i     = {{20{instr_rdata_i[31]}}, instr_rdata_i[31:20]};
        imm_s     = {{20{instr_rdata_i[31]}}, instr_rdata_i[31:25], instr_rdata_i[11:7]};
        imm_b     = {{19{instr_rdata_i[31]}}, instr_rdata_i[31], instr_rdata_i[7],
                     instr_rdata_i[30:25], instr_rdata_i[11:8], 1'b0};
        imm_u     = {instr_rdata_i[31:12], 12'b0};
        imm_j     = {{11{instr_rdata_i[31]}}, instr_rdata_i[31], instr_rdata_i[19:12],
                     instr_rdata_i[20], instr_rdata_i[30:21], 1'b0};
        writes_rd = 1'b0;
        ill       = 1'b0;

        dec_c     = '0;
        dec_c.rs1 = instr_rdata_i[15 +: RAW];
        dec_c.rs2 = instr_rdata_i[20 +: RAW];
        dec_c.rd  = instr_rdata_i[7 +: RAW];

        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_c.imm = imm_u;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                dec_c.imm  = imm_j;
                dec_c.jump = 1'b1;
                writes_rd  = 1'b1;
            end
            OPC_JALR: begin
                dec_c.imm   = imm_i;
                dec_c.reg_a = 1'b1;
                dec_c.jump  = 1'b1;
                writes_rd   = 1'b1;
                ill         = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_c.imm    = imm_b;
                dec_c.reg_a  = 1'b1;
                dec_c.reg_b  = 1'b1;
                dec_c.branch = 1'b1;
                ill          = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_c.imm      = imm_i;
                dec_c.reg_a    = 1'b1;
                dec_c.lsu_en   = 1'b1;
                dec_c.lsu_ctrl = {1'b0, funct3};
                writes_rd      = 1'b1;
                ill            = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_c.imm      = imm_s;
                dec_c.reg_a    = 1'b1;
                dec_c.reg_b    = 1'b1;
                dec_c.lsu_en   = 1'b1;
                dec_c.lsu_ctrl = {1'b1, funct3};
                ill            = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec_c.imm    = imm_i;
                dec_c.reg_a  = 1'b1;
                dec_c.alu_op = {(funct3 == 3'b101) ? instr_rdata_i[30] : 1'b0, funct3};
                writes_rd    = 1'b1;
                // Only the shift encodings constrain the upper immediate bits.
                if (funct3 == 3'b001) begin
                    ill = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                dec_c.reg_a  = 1'b1;
                dec_c.reg_b  = 1'b1;
                dec_c.alu_op = {instr_rdata_i[30], funct3};
                writes_rd    = 1'b1;
                if (funct7 == 7'b0100000) begin
                    ill = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else begin
                    ill = (funct7 != 7'b0000000);
                end
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
            end
            // Also catches instr[1:0] != 2'b11, since every base opcode ends in 11.
            default: ill = 1'b1;
        endcase

        // RV32E has only x0..x15: bit 4 of any register field in use is illegal.
        if (RVE && ((dec_c.reg_a && instr_rdata_i[19]) ||
                    (dec_c.reg_b && instr_rdata_i[24]) ||
                    (writes_rd   && instr_rdata_i[11]))) begin
            ill = 1'b1;
        end

        dec_c.rd_we   = writes_rd && (instr_rdata_i[11:7] != 5'd0);
        dec_c.illegal = ill;
        if (ill) begin
            dec_c.rd_we  = 1'b0;
            dec_c.lsu_en = 1'b0;
            dec_c.branch = 1'b0;
            dec_c.jump   = 1'b0;
        end
    end

    // live_q keeps ready low while in reset and until the first edge after it.
    assign instr_ready_o = live_q && (SKID_EN ? !skid_vld_q : (!main_vld_q || dec_ready_i));
    assign in_fire       = instr_valid_i && instr_ready_o;
    assign out_fire      = main_vld_q && dec_ready_i;

    // Output buffer: main register feeds dec_*, skid catches one word while main stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            live_q     <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;

            if (out_fire && main_q.illegal && !flush_i) begin
                sticky_q <= 1'b1;
            end else if (illegal_clr_i) begin
                sticky_q <= 1'b0;
            end

            if (flush_i) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
            end else if (SKID_EN) begin
                if (!main_vld_q || out_fire) begin
                    // Main is free this cycle; skid is older than any new word.
                    if (skid_vld_q) begin
                        main_q     <= skid_q;
                        main_vld_q <= 1'b1;
                        skid_vld_q <= 1'b0;
                    end else if (in_fire) begin
                        main_q     <= dec_c;
                        main_vld_q <= 1'b1;
                    end else begin
                        main_vld_q <= 1'b0;
                    end
                end else if (in_fire) begin
                    skid_q     <= dec_c;
                    skid_vld_q <= 1'b1;
                end
            end else begin
                if (in_fire) begin
                    main_q     <= dec_c;
                    main_vld_q <= 1'b1;
                end else if (out_fire) begin
                    main_vld_q <= 1'b0;
                end
            end
        end
    end

    assign dec_valid_o      = main_vld_q;
    assign dec_alu_op_o     = main_q.alu_op;
    assign dec_reg_a_o      = main_q.reg_a;
    assign dec_reg_b_o      = main_q.reg_b;
    assign dec_rs1_addr_o   = main_q.rs1;
    assign dec_rs2_addr_o   = main_q.rs2;
    assign dec_rd_addr_o    = main_q.rd;
    assign dec_rd_we_o      = main_q.rd_we;
    assign dec_imm_o        = main_q.imm;
    assign dec_lsu_en_o     = main_q.lsu_en;
    assign dec_lsu_ctrl_o   = main_q.lsu_ctrl;
    assign dec_branch_o     = main_q.branch;
    assign dec_jump_o       = main_q.jump;
    assign dec_illegal_o    = main_q.illegal;
    assign illegal_sticky_o = sticky_q;

endmodule

// File: tb/tb_jedro_1_decoder_pipe.sv
// tb_jedro_1_decoder_pipe: scoreboard bench for jedro_1_decoder_pipe.
// dut runs RV32I with skid buffer; dut_e (RV32E) shares all inputs and is
// inspected only for the register-range checks.
module tb_jedro_1_decoder_pipe;

    typedef struct packed {
        logic [3:0]  alu;
        logic        ra;
        logic        rb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic        lsu;
        logic [3:0]  ctl;
        logic        br;
        logic        jp;
        logic        il;
    } fld_t;

    typedef struct packed {
        logic [31:0] w;
        fld_t        f;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        instr_valid_i;
    logic [31:0] instr_rdata_i;
    logic        flush_i;
    logic        illegal_clr_i;
    logic        dec_ready_i;

    logic        rdy, vld, ra, rb, we, lsu, br, jp, il, sticky;
    logic [3:0]  alu, ctl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;

    logic        e_rdy, e_vld, e_ra, e_rb, e_we, e_lsu, e_br, e_jp, e_il, e_sticky;
    logic [3:0]  e_alu, e_ctl;
    logic [3:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_imm;

    int   n_cmp = 0;
    int   n_err = 0;
    sb_t  sb[$];
    sb_t  cur;
    bit   done;

    logic [31:0] vin[13];
    fld_t        vexp[13];

    jedro_1_decoder_pipe dut (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i), .instr_ready_o(rdy),
        .flush_i(flush_i), .illegal_clr_i(illegal_clr_i),
        .dec_valid_o(vld), .dec_ready_i(dec_ready_i),
        .dec_alu_op_o(alu), .dec_reg_a_o(ra), .dec_reg_b_o(rb),
        .dec_rs1_addr_o(rs1), .dec_rs2_addr_o(rs2), .dec_rd_addr_o(rd), .dec_rd_we_o(we),
        .dec_imm_o(imm), .dec_lsu_en_o(lsu), .dec_lsu_ctrl_o(ctl),
        .dec_branch_o(br), .dec_jump_o(jp), .dec_illegal_o(il),
        .illegal_sticky_o(sticky)
    );

    jedro_1_decoder_pipe #(.RVE(1'b1), .SKID_EN(1'b1)) dut_e (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i), .instr_ready_o(e_rdy),
        .flush_i(flush_i), .illegal_clr_i(illegal_clr_i),
        .dec_valid_o(e_vld), .dec_ready_i(dec_ready_i),
        .dec_alu_op_o(e_alu), .dec_reg_a_o(e_ra), .dec_reg_b_o(e_rb),
        .dec_rs1_addr_o(e_rs1), .dec_rs2_addr_o(e_rs2), .dec_rd_addr_o(e_rd), .dec_rd_we_o(e_we),
        .dec_imm_o(e_imm), .dec_lsu_en_o(e_lsu), .dec_lsu_ctrl_o(e_ctl),
        .dec_branch_o(e_br), .dec_jump_o(e_jp), .dec_illegal_o(e_il),
        .illegal_sticky_o(e_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic fld_t obs_main();
        fld_t f;
        f = '{alu, ra, rb, rs1, rs2, rd, we, imm, lsu, ctl, br, jp, il};
        return f;
    endfunction

    function automatic logic [63:0] obs_e_all();
        return {e_vld, e_rdy, e_sticky, e_alu, e_ra, e_rb, e_rs1, e_rs2, e_rd, e_we,
                e_imm, e_lsu, e_ctl, e_br, e_jp, e_il};
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst || flush_i) begin
            sb.delete();
        end else begin
            if (vld && dec_ready_i) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    check($sformatf("entry_%08h", e.w), 64'(obs_main()), 64'(e.f));
                end
            end
            if (instr_valid_i && rdy) sb.push_back(cur);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int idx);
        int n;
        instr_valid_i = 1'b1;
        instr_rdata_i = vin[idx];
        cur = '{vin[idx], vexp[idx]};
        n = 0;
        @(negedge clk);
        while (!rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept", 64'(rdy), 64'd1);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        dec_ready_i = 1'b1;
        while ((sb.size() != 0 || vld) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("ready_before_edge", 64'(rdy), 64'd0);
        @(posedge clk); #1;
        check("ready_after_reset", 64'(rdy), 64'd1);
    endtask

    initial begin
        vin[0]  = 32'hFFF00093; vexp[0]  = '{4'h0, 1'b1, 1'b0, 5'd0, 5'd31, 5'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vin[1]  = 32'h402081B3; vexp[1]  = '{4'h8, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vin[2]  = 32'h0020A423; vexp[2]  = '{4'h0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 32'h8, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0};
        vin[3]  = 32'hFFC12283; vexp[3]  = '{4'h0, 1'b1, 1'b0, 5'd2, 5'd28, 5'd5, 1'b1, 32'hFFFFFFFC, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0};
        vin[4]  = 32'hFE208CE3; vexp[4]  = '{4'h0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd25, 1'b0, 32'hFFFFFFF8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
        vin[5]  = 32'h010000EF; vexp[5]  = '{4'h0, 1'b0, 1'b0, 5'd0, 5'd16, 5'd1, 1'b1, 32'h10, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
        vin[6]  = 32'h123453B7; vexp[6]  = '{4'h0, 1'b0, 1'b0, 5'd8, 5'd3, 5'd7, 1'b1, 32'h12345000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vin[7]  = 32'h40325213; vexp[7]  = '{4'hD, 1'b1, 1'b0, 5'd4, 5'd3, 5'd4, 1'b1, 32'h403, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vin[8]  = 32'h00000000; vexp[8]  = '{4'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
        vin[9]  = 32'h40209133; vexp[9]  = '{4'h9, 1'b1, 1'b1, 5'd1, 5'd2, 5'd2, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
        vin[10] = 32'h00008067; vexp[10] = '{4'h0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
        vin[11] = 32'h00000073; vexp[11] = '{4'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vin[12] = 32'h00000833; vexp[12] = '{4'h0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd16, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        instr_valid_i = 1'b0;
        instr_rdata_i = 32'hFFFFFFFF;
        flush_i = 1'b0;
        illegal_clr_i = 1'b0;
        dec_ready_i = 1'b0;
        done = 1'b0;

        // Reset values, before any clock edge.
        #2;
        check("rst_valid", 64'(vld), 64'd0);
        check("rst_ready", 64'(rdy), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        check("rst_fields", 64'(obs_main()), 64'd0);
        @(posedge clk); #1;
        do_reset();

        // First-transaction latency with an empty pipe.
        dec_ready_i = 1'b1;
        send(0);
        check("latency_valid", 64'(vld), 64'd1);
        drain();

        // Stream every vector twice with random consumer back-pressure.
        fork
            begin
                for (int r = 0; r < 2; r++)
                    for (int i = 0; i < 13; i++) send(i);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    dec_ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        check("sticky_after_illegal", 64'(sticky), 64'd1);
        illegal_clr_i = 1'b1;
        @(posedge clk); #1;
        illegal_clr_i = 1'b0;
        check("sticky_cleared", 64'(sticky), 64'd0);

        // Skid fill: two words accepted, third stalled, then ordered drain.
        dec_ready_i = 1'b0;
        send(1);
        send(2);
        instr_valid_i = 1'b1;
        instr_rdata_i = vin[3];
        cur = '{vin[3], vexp[3]};
        @(negedge clk);
        check("skid_full_ready", 64'(rdy), 64'd0);
        check("stalled_valid", 64'(vld), 64'd1);
        @(posedge clk); #1;
        dec_ready_i = 1'b1;
        @(negedge clk);
        check("drain0_valid", 64'(vld), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain1_valid", 64'(vld), 64'd1);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        drain();

        // Flush with both entries full; the word offered alongside is dropped.
        dec_ready_i = 1'b0;
        send(4);
        send(5);
        flush_i = 1'b1;
        instr_valid_i = 1'b1;
        instr_rdata_i = vin[6];
        cur = '{vin[6], vexp[6]};
        @(posedge clk); #1;
        flush_i = 1'b0;
        instr_valid_i = 1'b0;
        check("flush_valid", 64'(vld), 64'd0);
        check("flush_ready", 64'(rdy), 64'd1);
        dec_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_no_output", 64'(vld), 64'd0);
        send(7);
        drain();

        // RV32E range check on rd = x16.
        do_reset();
        dec_ready_i = 1'b1;
        send(12);
        check("rve_valid", 64'(e_vld), 64'd1);
        check("rve_illegal", 64'(e_il), 64'd1);
        check("rve_rd_we", 64'(e_we), 64'd0);
        @(posedge clk); #1;
        check("rve_sticky_set", 64'(e_sticky), 64'd1);
        check("rv32i_sticky_clear", 64'(sticky), 64'd0);
        illegal_clr_i = 1'b1;
        @(posedge clk); #1;
        illegal_clr_i = 1'b0;
        check("rve_sticky_cleared", 64'(e_sticky), 64'd0);
        drain();

        // Asynchronous reset in the middle of a stalled stream.
        send(8);
        @(posedge clk); #1;
        check("sticky_before_rst", 64'(sticky), 64'd1);
        dec_ready_i = 1'b0;
        send(3);
        send(4);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(vld), 64'd0);
        check("async_rst_ready", 64'(rdy), 64'd0);
        check("async_rst_sticky", 64'(sticky), 64'd0);
        check("async_rst_fields", 64'(obs_main()), 64'd0);
        check("async_rst_rve_all", obs_e_all(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_async_rst", 64'(rdy), 64'd1);
        dec_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_discarded", 64'(vld), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
